// File: rtl/teller_scheduler_if.sv
// Bus bundle between the bank front end and the teller scheduler.
// The master side drives arrivals and desk status; the slave side is the scheduler.
interface teller_scheduler_if #(
  parameter int N_TELLERS = 3,
  parameter int CNT_W     = 3,
  parameter int ID_W      = 2,
  parameter int WAIT_W    = 5
);
  logic                 cust_in;
  logic [N_TELLERS-1:0] teller_done;
  logic [N_TELLERS-1:0] teller_en;
  logic [CNT_W-1:0]     q_count;
  logic                 q_empty;
  logic                 q_full;
  logic                 arrival_drop;
  logic [N_TELLERS-1:0] busy;
  logic                 assign_valid;
  logic [ID_W-1:0]      assign_id;
  logic [WAIT_W-1:0]    wait_est;

  modport master (
    output cust_in, teller_done, teller_en,
    input  q_count, q_empty, q_full, arrival_drop, busy, assign_valid, assign_id, wait_est
  );

  modport slave (
    input  cust_in, teller_done, teller_en,
    output q_count, q_empty, q_full, arrival_drop, busy, assign_valid, assign_id, wait_est
  );
endinterface

// File: rtl/teller_scheduler.sv
// Single-queue, multi-teller bank scheduler: counts waiting customers, grants the head
// customer to a free open desk round-robin, tracks desk busy state and estimates wait time.
module teller_scheduler #(
  parameter int N_TELLERS = 3,
  parameter int QDEPTH    = 7,
  parameter int CNT_W     = 3,
  parameter int ID_W      = 2,
  parameter int SVC_TIME  = 3,
  parameter int WAIT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  teller_scheduler_if.slave  bus
);

  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     q_count_q, q_count_d;
  logic [N_TELLERS-1:0] busy_q, busy_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 assign_valid_q;
  logic [ID_W-1:0]      assign_id_q;
  logic                 arrival_drop_q;
  logic [WAIT_W-1:0]    wait_est_q, wait_est_d;

  logic [N_TELLERS-1:0] avail_s;
  logic                 sel_found_s;
  logic [ID_W-1:0]      sel_s;
  logic                 grant_s;
  logic                 inc_s;
  int                   idx_s;
  int                   ntel_s;
  int                   est_s;

  assign bus.q_count      = q_count_q;
  assign bus.q_empty      = (q_count_q == CNT_W'(0));
  assign bus.q_full       = (q_count_q == CNT_W'(QDEPTH));
  assign bus.busy         = busy_q;
  assign bus.assign_valid = assign_valid_q;
  assign bus.assign_id    = assign_id_q;
  assign bus.arrival_drop = arrival_drop_q;
  assign bus.wait_est     = wait_est_q;

  // Round-robin pick, queue/busy/pointer next state and wait estimate.
  always_comb begin
    avail_s     = ~busy_q & bus.teller_en;
    sel_found_s = 1'b0;
    sel_s       = '0;
    idx_s       = 0;
    for (int k = 0; k < N_TELLERS; k++) begin
      idx_s = int'(rr_ptr_q) + k;
      if (idx_s >= N_TELLERS) begin
        idx_s = idx_s - N_TELLERS;
      end else begin
        idx_s = idx_s;
      end
      if (!sel_found_s && avail_s[idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = ID_W'(idx_s);
      end else begin
        sel_found_s = sel_found_s;
      end
    end

    grant_s = (state_q == S_GRANT) && sel_found_s;
    // Full is judged on the registered count, so a same-cycle grant never rescues an arrival.
    inc_s   = bus.cust_in & ~bus.q_full;

    case ({inc_s, grant_s})
      2'b10:   q_count_d = q_count_q + CNT_W'(1);
      2'b01:   q_count_d = q_count_q - CNT_W'(1);
      default: q_count_d = q_count_q;
    endcase

    busy_d = busy_q & ~bus.teller_done;
    if (grant_s) begin
      busy_d[sel_s] = 1'b1;
    end else begin
      busy_d = busy_d;
    end

    if (!grant_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (int'(sel_s) + 1 >= N_TELLERS) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = sel_s + ID_W'(1);
    end

    ntel_s = 0;
    for (int k = 0; k < N_TELLERS; k++) begin
      ntel_s = ntel_s + int'(bus.teller_en[k]);
    end
    if (q_count_q == CNT_W'(0)) begin
      est_s = 0;
    end else if (ntel_s == 0) begin
      est_s = WAIT_MAX;
    end else begin
      est_s = (SVC_TIME * int'(q_count_q) + ntel_s - 1) / ntel_s;
    end
    if (est_s > WAIT_MAX) begin
      wait_est_d = WAIT_W'(WAIT_MAX);
    end else begin
      wait_est_d = WAIT_W'(est_s);
    end
  end

  // Grant FSM and all registered state/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      q_count_q      <= '0;
      busy_q         <= '0;
      rr_ptr_q       <= '0;
      assign_valid_q <= 1'b0;
      assign_id_q    <= '0;
      arrival_drop_q <= 1'b0;
      wait_est_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((q_count_q != CNT_W'(0)) && (avail_s != '0)) begin
            state_q <= S_GRANT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GRANT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      q_count_q      <= q_count_d;
      busy_q         <= busy_d;
      rr_ptr_q       <= rr_ptr_d;
      assign_valid_q <= grant_s;
      assign_id_q    <= grant_s ? sel_s : assign_id_q;
      arrival_drop_q <= bus.cust_in & bus.q_full;
      wait_est_q     <= wait_est_d;
    end
  end

endmodule
